// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared widths, entry layout and tag wrap helper for the reorder buffer
package reorder_buffer_pkg;
  localparam int ROB_AW     = 4;
  localparam int ROB_SIZE   = 2 ** ROB_AW;
  localparam int REG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;

  localparam logic [ROB_AW-1:0]     ZERO_ROB  = '0;
  localparam logic [REG_WIDTH-1:0]  ZERO_REG  = '0;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic                  is_jump;
    logic                  mispredict;
    logic [REG_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0] value;
    logic [DATA_WIDTH-1:0] target_pc;
  } rob_entry_t;

  // Tag 0 means "no tag", so the pointer wraps from the last slot back to 1.
  function automatic logic [ROB_AW-1:0] next_tag(input logic [ROB_AW-1:0] t);
    return (t == ROB_AW'(ROB_SIZE - 1)) ? ROB_AW'(1) : t + ROB_AW'(1);
  endfunction
endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// rtl/reorder_buffer_rob_ptr.sv - wrapping tag counter (1..ROB_SIZE-1) with increment and synchronous clear
module reorder_buffer_rob_ptr
  import reorder_buffer_pkg::*;
(
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              inc,
  input  logic              clr,
  output logic [ROB_AW-1:0] ptr
);
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      ptr <= ROB_AW'(1);
    end else if (clr) begin
      ptr <= ROB_AW'(1);
    end else if (inc) begin
      ptr <= next_tag(ptr);
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retiring reorder buffer with CDB collection and mispredict flush
// Optional same-cycle CDB-to-query forwarding: ROB_CDB_BYPASS_EN
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_rdy,
  input  logic                  in_decoder_issue_enable,
  input  logic [REG_WIDTH-1:0]  in_decoder_rd,
  input  logic                  in_decoder_is_jump,
  output logic [ROB_AW-1:0]     out_decoder_reorder,
  output logic                  out_rob_full,
  input  logic [ROB_AW-1:0]     in_decoder_query_tag,
  output logic                  out_query_ready,
  output logic [DATA_WIDTH-1:0] out_query_value,
  input  logic                  in_cdb_enable,
  input  logic [ROB_AW-1:0]     in_cdb_reorder,
  input  logic [DATA_WIDTH-1:0] in_cdb_value,
  input  logic                  in_cdb_mispredict,
  input  logic [DATA_WIDTH-1:0] in_cdb_target_pc,
  output logic                  out_commit_enable,
  output logic [REG_WIDTH-1:0]  out_commit_rd_addr,
  output logic [DATA_WIDTH-1:0] out_commit_rd_value,
  output logic [ROB_AW-1:0]     out_commit_reorder,
  output logic                  out_flush_enable,
  output logic [DATA_WIDTH-1:0] out_flush_pc
);
  rob_entry_t        entries [ROB_SIZE];
  logic [ROB_AW-1:0] head;
  logic [ROB_AW-1:0] tail;
  logic [ROB_AW-1:0] count;
  logic              full;
  logic              commit_fire;
  logic              flush_fire;
  logic              issue_fire;
  logic              cdb_fire;
  rob_entry_t        head_e;
  rob_entry_t        q_e;

  assign head_e      = entries[head];
  assign full        = (count == ROB_AW'(ROB_SIZE - 1));
  assign commit_fire = in_rdy && (count != ZERO_ROB) && head_e.valid && head_e.ready;
  assign flush_fire  = commit_fire && head_e.mispredict;
  // Full is judged on the pre-commit count, and a flushing cycle drops all new work.
  assign issue_fire  = in_rdy && in_decoder_issue_enable && !full && !flush_fire;
  assign cdb_fire    = in_rdy && in_cdb_enable && (in_cdb_reorder != ZERO_ROB)
                       && entries[in_cdb_reorder].valid && !flush_fire;

  assign out_decoder_reorder = tail;
  assign out_rob_full        = full;

  reorder_buffer_rob_ptr u_head (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .inc    (commit_fire),
    .clr    (flush_fire),
    .ptr    (head)
  );

  reorder_buffer_rob_ptr u_tail (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .inc    (issue_fire),
    .clr    (flush_fire),
    .ptr    (tail)
  );

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int i = 0; i < ROB_SIZE; i++) entries[i] <= '0;
      count               <= ZERO_ROB;
      out_commit_enable   <= 1'b0;
      out_commit_rd_addr  <= ZERO_REG;
      out_commit_rd_value <= ZERO_DATA;
      out_commit_reorder  <= ZERO_ROB;
      out_flush_enable    <= 1'b0;
      out_flush_pc        <= ZERO_DATA;
    end else begin
      out_commit_enable <= commit_fire;
      out_flush_enable  <= flush_fire;
      if (commit_fire) begin
        out_commit_rd_addr  <= head_e.rd;
        out_commit_rd_value <= head_e.value;
        out_commit_reorder  <= head;
      end
      if (flush_fire) begin
        out_flush_pc <= head_e.target_pc;
        for (int i = 0; i < ROB_SIZE; i++) entries[i] <= '0;
        count <= ZERO_ROB;
      end else begin
        if (issue_fire) begin
          entries[tail] <= '{valid: 1'b1, ready: 1'b0, is_jump: in_decoder_is_jump,
                             mispredict: 1'b0, rd: in_decoder_rd,
                             value: ZERO_DATA, target_pc: ZERO_DATA};
        end
        if (cdb_fire) begin
          entries[in_cdb_reorder].ready      <= 1'b1;
          entries[in_cdb_reorder].value      <= in_cdb_value;
          entries[in_cdb_reorder].mispredict <= in_cdb_mispredict
                                                && entries[in_cdb_reorder].is_jump;
          entries[in_cdb_reorder].target_pc  <= in_cdb_target_pc;
        end
        if (commit_fire) entries[head] <= '0;
        count <= count + {{(ROB_AW-1){1'b0}}, issue_fire} - {{(ROB_AW-1){1'b0}}, commit_fire};
      end
    end
  end

  assign q_e = entries[in_decoder_query_tag];

  always_comb begin
    out_query_ready = 1'b0;
    out_query_value = q_e.value;
    if ((in_decoder_query_tag != ZERO_ROB) && q_e.valid) begin
      out_query_ready = q_e.ready;
`ifdef ROB_CDB_BYPASS_EN
      if (in_cdb_enable && (in_cdb_reorder == in_decoder_query_tag)) begin
        out_query_ready = 1'b1;
        out_query_value = in_cdb_value;
      end
`endif
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;
  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_rdy;
  logic        in_decoder_issue_enable;
  logic [4:0]  in_decoder_rd;
  logic        in_decoder_is_jump;
  logic [3:0]  out_decoder_reorder;
  logic        out_rob_full;
  logic [3:0]  in_decoder_query_tag;
  logic        out_query_ready;
  logic [31:0] out_query_value;
  logic        in_cdb_enable;
  logic [3:0]  in_cdb_reorder;
  logic [31:0] in_cdb_value;
  logic        in_cdb_mispredict;
  logic [31:0] in_cdb_target_pc;
  logic        out_commit_enable;
  logic [4:0]  out_commit_rd_addr;
  logic [31:0] out_commit_rd_value;
  logic [3:0]  out_commit_reorder;
  logic        out_flush_enable;
  logic [31:0] out_flush_pc;

  int checks = 0;
  int errors = 0;

`ifdef ROB_CDB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  always #5 in_clk = ~in_clk;

  reorder_buffer dut (
    .in_clk                  (in_clk),
    .in_rst                  (in_rst),
    .in_rdy                  (in_rdy),
    .in_decoder_issue_enable (in_decoder_issue_enable),
    .in_decoder_rd           (in_decoder_rd),
    .in_decoder_is_jump      (in_decoder_is_jump),
    .out_decoder_reorder     (out_decoder_reorder),
    .out_rob_full            (out_rob_full),
    .in_decoder_query_tag    (in_decoder_query_tag),
    .out_query_ready         (out_query_ready),
    .out_query_value         (out_query_value),
    .in_cdb_enable           (in_cdb_enable),
    .in_cdb_reorder          (in_cdb_reorder),
    .in_cdb_value            (in_cdb_value),
    .in_cdb_mispredict       (in_cdb_mispredict),
    .in_cdb_target_pc        (in_cdb_target_pc),
    .out_commit_enable       (out_commit_enable),
    .out_commit_rd_addr      (out_commit_rd_addr),
    .out_commit_rd_value     (out_commit_rd_value),
    .out_commit_reorder      (out_commit_reorder),
    .out_flush_enable        (out_flush_enable),
    .out_flush_pc            (out_flush_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    #1;
    in_rst = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val, input logic mp,
                     input logic [31:0] pc);
    in_cdb_enable     = 1'b1;
    in_cdb_reorder    = tag;
    in_cdb_value      = val;
    in_cdb_mispredict = mp;
    in_cdb_target_pc  = pc;
  endtask

  initial begin
    in_rst = 1'b1;
    in_rdy = 1'b1;
    in_decoder_issue_enable = 1'b0;
    in_decoder_rd = '0;
    in_decoder_is_jump = 1'b0;
    in_decoder_query_tag = '0;
    in_cdb_enable = 1'b0;
    in_cdb_reorder = '0;
    in_cdb_value = '0;
    in_cdb_mispredict = 1'b0;
    in_cdb_target_pc = '0;
    #1;
    check("rst_commit_en", 32'(out_commit_enable), 32'd0);
    check("rst_flush_en", 32'(out_flush_enable), 32'd0);
    check("rst_tail", 32'(out_decoder_reorder), 32'd1);
    check("rst_full", 32'(out_rob_full), 32'd0);
    tick();
    in_rst = 1'b0;

    // single issue, CDB, commit
    in_decoder_issue_enable = 1'b1;
    in_decoder_rd = 5'd5;
    tick();
    in_decoder_issue_enable = 1'b0;
    check("issue_tail", 32'(out_decoder_reorder), 32'd2);
    cdb(4'd1, 32'h1234, 1'b0, 32'h0);
    in_decoder_query_tag = 4'd1;
    #1;
    check("bypass_ready", 32'(out_query_ready), 32'(BYP));
    tick();
    in_cdb_enable = 1'b0;
    #1;
    check("no_early_commit", 32'(out_commit_enable), 32'd0);
    check("query_ready", 32'(out_query_ready), 32'd1);
    check("query_value", out_query_value, 32'h1234);
    tick();
    check("c1_en", 32'(out_commit_enable), 32'd1);
    check("c1_rd", 32'(out_commit_rd_addr), 32'd5);
    check("c1_val", out_commit_rd_value, 32'h1234);
    check("c1_tag", 32'(out_commit_reorder), 32'd1);
    tick();
    check("c1_pulse_end", 32'(out_commit_enable), 32'd0);

    // fill to capacity, then out-of-order completion
    do_reset();
    in_decoder_issue_enable = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      in_decoder_rd = 5'(i);
      tick();
    end
    check("full_flag", 32'(out_rob_full), 32'd1);
    check("full_tail_wrap", 32'(out_decoder_reorder), 32'd1);
    in_decoder_rd = 5'd31;
    tick();
    in_decoder_issue_enable = 1'b0;
    check("full_issue_ignored_tail", 32'(out_decoder_reorder), 32'd1);
    check("full_still", 32'(out_rob_full), 32'd1);
    cdb(4'd3, 32'h333, 1'b0, 32'h0);
    tick();
    cdb(4'd2, 32'h222, 1'b0, 32'h0);
    tick();
    cdb(4'd1, 32'h111, 1'b0, 32'h0);
    tick();
    in_cdb_enable = 1'b0;
    check("ooo_wait", 32'(out_commit_enable), 32'd0);
    tick();
    check("ooo_c1_tag", 32'(out_commit_reorder), 32'd1);
    check("ooo_c1_val", out_commit_rd_value, 32'h111);
    check("ooo_not_full", 32'(out_rob_full), 32'd0);
    tick();
    check("ooo_c2_tag", 32'(out_commit_reorder), 32'd2);
    check("ooo_c2_rd", 32'(out_commit_rd_addr), 32'd2);
    tick();
    check("ooo_c3_en", 32'(out_commit_enable), 32'd1);
    check("ooo_c3_tag", 32'(out_commit_reorder), 32'd3);
    tick();
    check("ooo_done", 32'(out_commit_enable), 32'd0);

    // mispredicted jump at head
    do_reset();
    in_decoder_issue_enable = 1'b1;
    in_decoder_is_jump = 1'b1;
    in_decoder_rd = 5'd1;
    tick();
    in_decoder_is_jump = 1'b0;
    in_decoder_rd = 5'd2;
    tick();
    in_decoder_rd = 5'd3;
    tick();
    in_decoder_issue_enable = 1'b0;
    cdb(4'd2, 32'h22, 1'b0, 32'h0);
    in_decoder_query_tag = 4'd2;
    #1;
    check("bypass_tag2_ready", 32'(out_query_ready), 32'(BYP));
    check("bypass_tag2_val", out_query_value, BYP ? 32'h22 : 32'h0);
    tick();
    cdb(4'd1, 32'h44, 1'b1, 32'h100);
    tick();
    in_decoder_issue_enable = 1'b1;
    in_decoder_rd = 5'd4;
    cdb(4'd3, 32'h33, 1'b0, 32'h0);
    tick();
    in_decoder_issue_enable = 1'b0;
    in_cdb_enable = 1'b0;
    check("mp_commit_en", 32'(out_commit_enable), 32'd1);
    check("mp_commit_rd", 32'(out_commit_rd_addr), 32'd1);
    check("mp_commit_val", out_commit_rd_value, 32'h44);
    check("mp_flush_en", 32'(out_flush_enable), 32'd1);
    check("mp_flush_pc", out_flush_pc, 32'h100);
    check("mp_tail_reset", 32'(out_decoder_reorder), 32'd1);
    check("mp_not_full", 32'(out_rob_full), 32'd0);
    cdb(4'd2, 32'h99, 1'b0, 32'h0);
    in_decoder_query_tag = 4'd2;
    #1;
    check("mp_stale_query", 32'(out_query_ready), 32'd0);
    tick();
    in_cdb_enable = 1'b0;
    #1;
    check("mp_flush_pulse_end", 32'(out_flush_enable), 32'd0);
    check("mp_commit_pulse_end", 32'(out_commit_enable), 32'd0);
    check("mp_cdb_ignored", 32'(out_query_ready), 32'd0);
    tick();
    check("mp_no_commit", 32'(out_commit_enable), 32'd0);

    // global stall
    do_reset();
    in_decoder_issue_enable = 1'b1;
    in_decoder_rd = 5'd7;
    tick();
    in_decoder_issue_enable = 1'b0;
    cdb(4'd1, 32'h77, 1'b0, 32'h0);
    tick();
    in_cdb_enable = 1'b0;
    in_rdy = 1'b0;
    tick();
    tick();
    check("stall_no_commit", 32'(out_commit_enable), 32'd0);
    in_decoder_issue_enable = 1'b1;
    in_decoder_rd = 5'd8;
    tick();
    in_decoder_issue_enable = 1'b0;
    check("stall_no_issue", 32'(out_decoder_reorder), 32'd2);
    check("stall_no_commit2", 32'(out_commit_enable), 32'd0);
    in_rdy = 1'b1;
    tick();
    check("resume_commit_en", 32'(out_commit_enable), 32'd1);
    check("resume_commit_val", out_commit_rd_value, 32'h77);
    check("resume_commit_tag", 32'(out_commit_reorder), 32'd1);

    // asynchronous reset with work in flight
    do_reset();
    in_decoder_issue_enable = 1'b1;
    in_decoder_rd = 5'd9;
    tick();
    in_decoder_rd = 5'd10;
    tick();
    in_decoder_issue_enable = 1'b0;
    cdb(4'd1, 32'h5, 1'b0, 32'h0);
    tick();
    in_cdb_enable = 1'b0;
    tick();
    check("pre_rst_commit", 32'(out_commit_enable), 32'd1);
    check("pre_rst_tail", 32'(out_decoder_reorder), 32'd3);
    in_rst = 1'b1;
    #1;
    check("async_rst_commit", 32'(out_commit_enable), 32'd0);
    check("async_rst_rd", 32'(out_commit_rd_addr), 32'd0);
    check("async_rst_tail", 32'(out_decoder_reorder), 32'd1);
    in_decoder_query_tag = 4'd2;
    #1;
    check("async_rst_query", 32'(out_query_ready), 32'd0);
    in_rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer that allocates rename tags at issue and collects results from the common data bus (CDB).
- Retires entries in program order on the commit interface consumed by the tagged register file.
- Drives the pipeline-wide flush on a mispredicted branch or jump.
- Sits between decoder/issue, the CDB, and the register file.

Parameters:
- ROB_SIZE, 16: number of tag slots. Tag 0 is reserved as "no tag", so usable entries are ROB_SIZE-1 (tags 1..15).
- ROB_AW, 4: tag width; ROB_SIZE = 2**ROB_AW.

Ports:
- in_clk  input  1  clock
- in_rst  input  1  reset, asynchronous, active-high
- in_rdy  input  1  global enable; when low, no state changes
- in_decoder_issue_enable  input  1  allocate one entry this cycle
- in_decoder_rd  input  5  destination register (0 = no writeback)
- in_decoder_is_jump  input  1  entry is a branch/jalr, eligible for flush
- out_decoder_reorder  output  ROB_AW  tag to be assigned by the next issue (= tail)
- out_rob_full  output  1  no free entry
- in_decoder_query_tag  input  ROB_AW  tag of a busy source operand
- out_query_ready  output  1  queried entry has its result
- out_query_value  output  32  queried entry's result
- in_cdb_enable  input  1  result broadcast
- in_cdb_reorder  input  ROB_AW  producing tag
- in_cdb_value  input  32  result value
- in_cdb_mispredict  input  1  branch outcome differs from prediction
- in_cdb_target_pc  input  32  correct PC on mispredict
- out_commit_enable  output  1  one-cycle commit pulse
- out_commit_rd_addr  output  5  register written
- out_commit_rd_value  output  32  value written
- out_commit_reorder  output  ROB_AW  tag retired
- out_flush_enable  output  1  one-cycle flush pulse
- out_flush_pc  output  32  redirect PC

Behaviour:
- Async reset:
  - head = tail = 1, count = 0, all entry valid/ready/mispredict bits cleared.
  - All registered outputs 0; out_decoder_reorder = 1, out_rob_full = 0.
- Pointer wrap: increment is 15 -> 1, never 0.
- Full/empty: out_rob_full = (count == ROB_SIZE-1); empty when count == 0.
- Issue: when in_rdy, issue_enable and !full, write {valid=1, ready=0, rd, is_jump} at tail, then advance tail.
  - Issue while full is ignored; the decoder must not issue.
  - Full is evaluated on the pre-commit count; a same-cycle commit does not admit the issue.
- CDB write: when in_rdy and in_cdb_enable and the entry at in_cdb_reorder is valid, set ready, value and mispredict (mispredict only if is_jump), and store the target PC.
  - A CDB write to an invalid tag or to tag 0 is ignored.
- Commit: at most one per cycle. When in_rdy, count > 0 and head is valid and ready, on the next edge:
  - out_commit_enable = 1, with rd_addr, value and reorder = head.
  - Clear the entry, advance head, decrement count.
  - rd = 0 still pulses commit; the register file discards the write.
- Mispredicted head: commit as above (jalr link writeback) and also assert out_flush_enable = 1 with out_flush_pc = stored target in the same cycle.
  - On the same edge, clear all entries and set head = tail = 1, count = 0.
  - Issue and CDB inputs in that cycle are ignored.
- Simultaneous issue and commit: count is unchanged, both pointers advance.
- Commit and flush outputs are pulses: deasserted on every cycle without a commit, including when in_rdy = 0.
- Query: combinational read of ready/value[in_decoder_query_tag]. Tag 0 or an invalid entry returns ready = 0.

Optional Feature:
- Macro ROB_CDB_BYPASS_EN.
- Defined: if in_cdb_enable and in_cdb_reorder == in_decoder_query_tag (nonzero, valid entry), the query returns ready = 1 and value = in_cdb_value in the same cycle.
- Undefined: the query sees only stored state, so the result is visible one cycle after the CDB broadcast.

Decomposition:
- Shared def.v holds:
  - ROB_WIDTH, ROB_SIZE, ZERO_ROB, REG_WIDTH, DATA_WIDTH, ZERO_DATA, ZERO_REG, TRUE/FALSE.
  - A new ROB_ENTRY range macro.
- One natural sub-module: rob_ptr, a wrapping tag counter (1..ROB_SIZE-1 with increment and synchronous clear), instantiated for head and tail.

Test Plan:
- Issue rd = 5, then CDB tag 1 value 0x1234 -> next edge: commit_enable = 1, rd_addr = 5, value 0x1234, reorder = 1. Following cycle: commit_enable = 0.
- Issue 15 entries with no CDB -> out_rob_full = 1, out_decoder_reorder = 1. A 16th issue is ignored; count stays at 15.
- Complete tags 3, 2, 1 out of order -> commits occur in order 1, 2, 3 on consecutive cycles.
- Issue a jump (rd = 1) at tag 1 plus two ALU ops, then CDB tag 1 mispredict with target 0x100 -> commit rd = 1, flush_enable = 1, flush_pc = 0x100. Afterwards count = 0, out_decoder_reorder = 1, and later CDB writes to tag 2 are ignored.
- Hold in_rdy = 0 with a ready head -> no commit pulse and no state change; commit occurs one edge after in_rdy returns to 1.
- Assert in_rst mid-operation (entries outstanding) -> all outputs clear immediately without a clock edge. With ROB_CDB_BYPASS_EN, a query of tag 2 during its CDB cycle returns ready = 1 and the CDB value.
